sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised synchronous FIFO for the UART receive path, buffering received bytes between the byte assembler and the downstream consumer. It generalises the existing single-purpose byte FIFO with configurable width and depth, true simultaneous read/write, registered level and threshold flags, sticky error flags, and a selectable first-word-fall-through read mode. Single clock domain.

## Interface

- DATA_W, 8, data word width in bits
- DEPTH, 16, number of storage words; any integer ≥ 2 (not restricted to powers of two)
- AFULL_TH, DEPTH-2, almost_full asserts when level ≥ AFULL_TH
- AEMPTY_TH, 2, almost_empty asserts when level ≤ AEMPTY_TH
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- LVL_W, $clog2(DEPTH+1), level width (derived, not overridden)

Ports:

- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request (standard) / pop (FWFT)
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data holds a valid word
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level ≥ AFULL_TH
- almost_empty  out  1  level ≤ AEMPTY_TH
- level  out  LVL_W  stored word count, 0..DEPTH
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow and underflow

## Operation

- Write accepted: wr_en && (!full || rd_accept). Read accepted (rd_accept): rd_en && !empty.
- Pointers wr_ptr/rd_ptr range 0..DEPTH-1; increment on accept; DEPTH-1 wraps to 0.
- level: +1 write only, −1 read only, unchanged for both or neither. Never derived from pointer difference.
- Full with simultaneous rd_en and wr_en: both accepted, level stays DEPTH, no overflow.
- Empty with simultaneous rd_en and wr_en: write accepted, read rejected, underflow set, level → 1.
- Rejected ops do not move pointers or alter memory.
- Standard (FWFT=0): accepted read registers mem[rd_ptr] into rd_data; rd_valid high for exactly one cycle; rd_data holds its value otherwise.
- FWFT=1: rd_data = mem[rd_ptr] combinationally, rd_valid = !empty; rd_en pops the head.
- overflow/underflow set on rejected op; cleared only by clr_err or reset; set wins over clr_err in the same cycle.
- Reset values: pointers 0, level 0, empty 1, full 0, almost_full 0, almost_empty 1, rd_valid 0, rd_data 0, overflow 0, underflow 0. Memory not reset.
- Reset mid-operation: all contents discarded; wr_en/rd_en ignored in the reset cycle.

## Timing

- All flags and level registered; update on the edge that accepts the op.
- Write at edge n: empty low, level 1 after edge n; standard read possible in cycle n+1.
- Standard read latency 1: rd_en accepted at edge n → rd_data/rd_valid valid after edge n.
- FWFT: written word visible on rd_data after the edge that writes it into empty FIFO.
- Back-to-back reads/writes every cycle sustained, no bubbles.

## Structure

- Package fifo_pkg: ptr_inc function (wrap at DEPTH-1), error-flag bit indices.
- Sub-module fifo_ram: DEPTH × DATA_W simple dual-port, sync write, read mode set by FWFT (registered vs. asynchronous). Control, level and flags in sync_fifo.

## Test plan

- DATA_W=8, DEPTH=16: write 0x00..0x0F → full=1, level=16, almost_full from level 14; read 16 → same order, empty=1.
- Full FIFO, wr_en and rd_en together 5 cycles → level stays 16, overflow=0, output order preserved.
- Empty FIFO, rd_en alone → underflow=1, rd_valid=0; clr_err → underflow=0.
- Empty, rd_en+wr_en 0xA5 together → level=1, underflow=1; next read returns 0xA5.
- DEPTH=10 (non-power-of-two): 25 writes/reads interleaved → pointers wrap at 9, data intact.
- Reset asserted with level=7 → next cycle level=0, empty=1, flags cleared; FWFT=1 variant: written 0x3C appears on rd_data one edge after write.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the receive-path FIFO: pointer wrap helper and error-flag layout.
package fifo_pkg;

    localparam int unsigned ERR_W   = 2;
    localparam int unsigned ERR_OVF = 0;
    localparam int unsigned ERR_UDF = 1;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage; read port is registered (FWFT=0) or asynchronous (FWFT=1).
module fifo_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned FWFT   = 0,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    if (FWFT != 0) begin : g_async
        logic unused_c;
        assign unused_c = re ^ reset;
        assign rdata    = mem_q[raddr];
    end else begin : g_reg
        logic [DATA_W-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem_q[raddr];
            end
        end
        assign rdata = rdata_q;
    end

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO for the UART receive path with registered level/flags,
// sticky error flags and optional first-word-fall-through read.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2,
    parameter int unsigned FWFT      = 0,
    localparam int unsigned LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             rd_valid_q, rd_valid_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             wr_accept_c;
    logic             rd_accept_c;
    logic [DATA_W-1:0] ram_rdata;

    // Accept decisions, pointer/level update and flag precompute from the next level.
    always_comb begin
        rd_accept_c = rd_en && !empty_q;
        wr_accept_c = wr_en && (!full_q || rd_accept_c);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        err_d       = clr_err ? '0 : err_q;
        rd_valid_d  = rd_accept_c;

        if (wr_accept_c) begin
            wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (rd_accept_c) begin
            rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end

        case ({wr_accept_c, rd_accept_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A rejected op sets its flag even when clr_err is asserted in the same cycle.
        if (wr_en && !wr_accept_c) begin
            err_d[ERR_OVF] = 1'b1;
        end
        if (rd_en && empty_q) begin
            err_d[ERR_UDF] = 1'b1;
        end

        full_d   = (32'(level_d) == DEPTH);
        empty_d  = (level_d == '0);
        afull_d  = (32'(level_d) >= AFULL_TH);
        aempty_d = (32'(level_d) <= AEMPTY_TH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            err_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FWFT   (FWFT),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_accept_c && !reset),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_accept_c && !reset),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign rd_data      = ram_rdata;
    assign rd_valid     = (FWFT != 0) ? !empty_q : rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign overflow     = err_q[ERR_OVF];
    assign underflow    = err_q[ERR_UDF];

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: standard DEPTH=16, non-power-of-two DEPTH=10, and FWFT variants.
module tb_sync_fifo;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Instance A: DEPTH=16 standard read
    logic       a_wr_en, a_rd_en, a_clr;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [4:0] a_level;

    // Instance B: DEPTH=10 standard read
    logic       b_wr_en, b_rd_en, b_clr;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [3:0] b_level;

    // Instance C: DEPTH=16 first-word-fall-through
    logic       c_wr_en, c_rd_en, c_clr;
    logic [7:0] c_wr_data, c_rd_data;
    logic       c_rd_valid, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
    logic [4:0] c_level;

    sync_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_a (
        .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .level(a_level), .overflow(a_ovf),
        .underflow(a_udf), .clr_err(a_clr)
    );

    sync_fifo #(.DATA_W(8), .DEPTH(10), .FWFT(0)) u_b (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .level(b_level), .overflow(b_ovf),
        .underflow(b_udf), .clr_err(b_clr)
    );

    sync_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_c (
        .clk(clk), .reset(reset), .wr_en(c_wr_en), .wr_data(c_wr_data), .rd_en(c_rd_en),
        .rd_data(c_rd_data), .rd_valid(c_rd_valid), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .level(c_level), .overflow(c_ovf),
        .underflow(c_udf), .clr_err(c_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_wr_en = 0; a_rd_en = 0; a_clr = 0; a_wr_data = '0;
        b_wr_en = 0; b_rd_en = 0; b_clr = 0; b_wr_data = '0;
        c_wr_en = 0; c_rd_en = 0; c_clr = 0; c_wr_data = '0;
        tick();
        tick();

        chk("a_rst_level", 32'(a_level), 32'd0);
        chk("a_rst_empty", 32'(a_empty), 32'd1);
        chk("a_rst_full", 32'(a_full), 32'd0);
        chk("a_rst_af", 32'(a_af), 32'd0);
        chk("a_rst_ae", 32'(a_ae), 32'd1);
        chk("a_rst_rdv", 32'(a_rd_valid), 32'd0);
        chk("a_rst_rdata", 32'(a_rd_data), 32'd0);
        chk("a_rst_ovf", 32'(a_ovf), 32'd0);
        chk("a_rst_udf", 32'(a_udf), 32'd0);
        chk("b_rst_state", {22'd0, b_rd_data, b_level, b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf},
            {22'd0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        chk("c_rst_state", {27'd0, c_level}, 32'd0);
        chk("c_rst_flags", {25'd0, c_rd_valid, c_full, c_empty, c_af, c_ae, c_ovf, c_udf},
            {25'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        reset = 1'b0;

        // Fill A with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            a_wr_en = 1; a_wr_data = 8'(i);
            tick();
            chk("a_fill_level", 32'(a_level), 32'(i + 1));
            chk("a_fill_af", 32'(a_af), 32'((i + 1) >= 14));
            chk("a_fill_ae", 32'(a_ae), 32'((i + 1) <= 2));
        end
        a_wr_en = 0;
        chk("a_full", 32'(a_full), 32'd1);
        chk("a_full_empty", 32'(a_empty), 32'd0);

        // Drain A in order
        for (int i = 0; i < 16; i++) begin
            a_rd_en = 1;
            tick();
            chk("a_rd_valid", 32'(a_rd_valid), 32'd1);
            chk("a_rd_data", 32'(a_rd_data), 32'(i));
        end
        a_rd_en = 0;
        tick();
        chk("a_rdv_pulse", 32'(a_rd_valid), 32'd0);
        chk("a_rd_hold", 32'(a_rd_data), 32'h0F);
        chk("a_drained_empty", 32'(a_empty), 32'd1);
        chk("a_drained_level", 32'(a_level), 32'd0);

        // Refill, then overflow on a lone write while full
        for (int i = 0; i < 16; i++) begin
            a_wr_en = 1; a_wr_data = 8'(8'h10 + i);
            tick();
        end
        a_wr_data = 8'hEE;
        tick();
        a_wr_en = 0;
        chk("a_ovf_set", 32'(a_ovf), 32'd1);
        chk("a_ovf_level", 32'(a_level), 32'd16);
        a_clr = 1;
        tick();
        a_clr = 0;
        chk("a_ovf_clr", 32'(a_ovf), 32'd0);

        // Full with simultaneous read and write
        for (int k = 0; k < 5; k++) begin
            a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'(8'h20 + k);
            tick();
            chk("a_rw_data", 32'(a_rd_data), 32'(8'h10 + k));
            chk("a_rw_level", 32'(a_level), 32'd16);
            chk("a_rw_ovf", 32'(a_ovf), 32'd0);
        end
        a_wr_en = 0;
        for (int k = 0; k < 16; k++) begin
            a_rd_en = 1;
            tick();
            chk("a_rw_drain", 32'(a_rd_data), (k < 11) ? 32'(8'h15 + k) : 32'(8'h20 + k - 11));
        end
        a_rd_en = 0;
        tick();
        chk("a_rw_empty", 32'(a_empty), 32'd1);

        // Underflow on empty, clear, and set-wins-over-clear
        a_rd_en = 1;
        tick();
        a_rd_en = 0;
        chk("a_udf_set", 32'(a_udf), 32'd1);
        chk("a_udf_rdv", 32'(a_rd_valid), 32'd0);
        a_clr = 1;
        tick();
        a_clr = 0;
        chk("a_udf_clr", 32'(a_udf), 32'd0);
        a_rd_en = 1; a_clr = 1;
        tick();
        a_rd_en = 0;
        chk("a_udf_setwins", 32'(a_udf), 32'd1);
        tick();
        a_clr = 0;
        chk("a_udf_clr2", 32'(a_udf), 32'd0);

        // Empty with simultaneous read and write of 0xA5
        a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'hA5;
        tick();
        a_wr_en = 0; a_rd_en = 0;
        chk("a_e_rw_level", 32'(a_level), 32'd1);
        chk("a_e_rw_udf", 32'(a_udf), 32'd1);
        chk("a_e_rw_rdv", 32'(a_rd_valid), 32'd0);
        chk("a_e_rw_empty", 32'(a_empty), 32'd0);
        a_rd_en = 1; a_clr = 1;
        tick();
        a_rd_en = 0; a_clr = 0;
        chk("a_e_rw_data", 32'(a_rd_data), 32'hA5);
        chk("a_e_rw_rdv2", 32'(a_rd_valid), 32'd1);
        chk("a_e_rw_udf2", 32'(a_udf), 32'd0);
        chk("a_e_rw_level2", 32'(a_level), 32'd0);

        // B: 25 writes/reads interleaved across two pointer wraps at 9
        for (int i = 0; i < 3; i++) begin
            b_wr_en = 1; b_wr_data = 8'(8'h40 + i);
            tick();
        end
        for (int k = 0; k < 22; k++) begin
            b_wr_en = 1; b_rd_en = 1; b_wr_data = 8'(8'h43 + k);
            tick();
            chk("b_wrap_data", 32'(b_rd_data), 32'(8'h40 + k));
            chk("b_wrap_level", 32'(b_level), 32'd3);
        end
        b_wr_en = 0;
        for (int k = 22; k < 25; k++) begin
            b_rd_en = 1;
            tick();
            chk("b_tail_data", 32'(b_rd_data), 32'(8'h40 + k));
        end
        b_rd_en = 0;
        tick();
        chk("b_empty", 32'(b_empty), 32'd1);
        for (int i = 0; i < 10; i++) begin
            b_wr_en = 1; b_wr_data = 8'(8'h60 + i);
            tick();
        end
        b_wr_en = 0;
        chk("b_full", 32'(b_full), 32'd1);
        chk("b_full_level", 32'(b_level), 32'd10);
        chk("b_full_af", 32'(b_af), 32'd1);
        chk("b_full_ae", 32'(b_ae), 32'd0);
        b_wr_en = 1; b_wr_data = 8'hFF;
        tick();
        b_wr_en = 0;
        chk("b_ovf", 32'(b_ovf), 32'd1);
        b_rd_en = 1;
        tick();
        b_rd_en = 0;
        chk("b_first_after_wrap", 32'(b_rd_data), 32'h60);

        // C: first-word-fall-through
        c_wr_en = 1; c_wr_data = 8'h3C;
        tick();
        c_wr_en = 0;
        chk("c_fwft_data", 32'(c_rd_data), 32'h3C);
        chk("c_fwft_rdv", 32'(c_rd_valid), 32'd1);
        c_wr_en = 1; c_wr_data = 8'h5A;
        tick();
        c_wr_en = 0;
        chk("c_head_hold", 32'(c_rd_data), 32'h3C);
        chk("c_level2", 32'(c_level), 32'd2);
        c_rd_en = 1;
        tick();
        chk("c_pop1_data", 32'(c_rd_data), 32'h5A);
        chk("c_pop1_level", 32'(c_level), 32'd1);
        chk("c_pop1_rdv", 32'(c_rd_valid), 32'd1);
        tick();
        c_rd_en = 0;
        chk("c_pop2_empty", 32'(c_empty), 32'd1);
        chk("c_pop2_rdv", 32'(c_rd_valid), 32'd0);

        // A: reset with level 7 discards contents and ignores a concurrent write
        for (int i = 0; i < 7; i++) begin
            a_wr_en = 1; a_wr_data = 8'(8'h70 + i);
            tick();
        end
        a_wr_en = 0;
        chk("a_pre_rst_level", 32'(a_level), 32'd7);
        reset = 1; a_wr_en = 1; a_wr_data = 8'hFF;
        tick();
        reset = 0; a_wr_en = 0;
        chk("a_mrst_level", 32'(a_level), 32'd0);
        chk("a_mrst_empty", 32'(a_empty), 32'd1);
        chk("a_mrst_flags", {28'd0, a_full, a_af, a_ae, a_rd_valid}, {28'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        chk("a_mrst_rdata", 32'(a_rd_data), 32'd0);
        chk("a_mrst_err", {30'd0, a_ovf, a_udf}, 32'd0);
        a_wr_en = 1; a_wr_data = 8'h77;
        tick();
        a_wr_en = 0; a_rd_en = 1;
        tick();
        a_rd_en = 0;
        chk("a_post_rst_data", 32'(a_rd_data), 32'h77);
        chk("a_post_rst_empty", 32'(a_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
